// File: rtl/arith_pkg.sv
// Shared types and constants for the serial add/subtract datapath.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;

endpackage

// File: rtl/addsub_slice.sv
// Combinational DIGIT-bit ripple slice: full adder chain for add, restador
// borrow chain for subtract.
module addsub_slice
  import arith_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic [DIGIT:0] w_c;

  // Sum bit is identical for both modes; only the carry/borrow generate differs.
  always_comb begin
    s      = '0;
    w_c    = '0;
    w_c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = a[i] ^ b[i] ^ w_c[i];
      if (mode == MODE_ADD)
        w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
      else
        w_c[i+1] = (~a[i] & b[i]) | (~a[i] & w_c[i]) | (b[i] & w_c[i]);
    end
  end

  assign cout = w_c[DIGIT];

endmodule

// File: rtl/serial_addsub.sv
// Sequential WIDTH-bit adder/subtractor processing DIGIT bits per clock
// through a single reusable ripple slice, with valid/ready on both sides.
module serial_addsub
  import arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_paramCheck
    $error("serial_addsub: WIDTH must be >= 2 and divisible by DIGIT");
  end

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_mode;
  logic             r_aMsb;
  logic             r_bMsb;
  logic             r_carry;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_outValid;
  logic             r_inReady;

  logic [DIGIT-1:0] w_s;
  logic             w_cout;
  logic [WIDTH-1:0] w_sNext;
  logic             w_sMsb;
  logic             w_ovf;

  addsub_slice #(.DIGIT(DIGIT)) u_slice (
    .a    (r_a[DIGIT-1:0]),
    .b    (r_b[DIGIT-1:0]),
    .cin  (r_carry),
    .mode (r_mode),
    .s    (w_s),
    .cout (w_cout)
  );

  // New digits enter at the top so the LSB digit ends up at bit 0 after N steps.
  if (N == 1) begin : g_sSingle
    assign w_sNext = w_s;
  end else begin : g_sShift
    assign w_sNext = {w_s, r_s[WIDTH-1:DIGIT]};
  end

  assign w_sMsb = w_s[DIGIT-1];
  assign w_ovf  = (r_mode == MODE_ADD) ? ((r_aMsb == r_bMsb) && (w_sMsb != r_aMsb))
                                       : ((r_aMsb != r_bMsb) && (w_sMsb != r_aMsb));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_mode     <= MODE_SUB;
      r_aMsb     <= 1'b0;
      r_bMsb     <= 1'b0;
      r_carry    <= 1'b0;
      r_s        <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
      r_outValid <= 1'b0;
      r_inReady  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a       <= A;
            r_b       <= B;
            r_mode    <= mode;
            r_aMsb    <= A[WIDTH-1];
            r_bMsb    <= B[WIDTH-1];
            r_cnt     <= '0;
            r_carry   <= 1'b0;
            r_inReady <= 1'b0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_cout;
          r_cout  <= w_cout;
          r_s     <= w_sNext;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST_CNT) begin
            r_ovf      <= w_ovf;
            r_zero     <= (w_sNext == '0);
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_inReady <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign S         = r_s;
  assign Cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: an 8-bit/1-digit unit and a 16-bit/4-digit unit.
module tb_serial_addsub;

  logic clk;
  logic rst;

  logic        inValid8, inReady8, outValid8, outReady8, mode8;
  logic [7:0]  a8, b8, s8;
  logic        cout8, ovf8, zero8;

  logic        inValid16, inReady16, outValid16, outReady16, mode16;
  logic [15:0] a16, b16, s16;
  logic        cout16, ovf16, zero16;

  int errors;
  int checks;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(inValid8), .in_ready(inReady8),
    .A(a8), .B(b8), .mode(mode8),
    .out_valid(outValid8), .out_ready(outReady8),
    .S(s8), .Cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(inValid16), .in_ready(inReady16),
    .A(a16), .B(b16), .mode(mode16),
    .out_valid(outValid16), .out_ready(outReady16),
    .S(s16), .Cout(cout16), .ovf(ovf16), .zero(zero16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one operand set to the 8-bit unit and counts edges until out_valid.
  task automatic doOp8(input logic [7:0] a, input logic [7:0] b, input logic m, output int lat);
    a8 = a; b8 = b; mode8 = m; inValid8 = 1'b1;
    @(posedge clk); #1;
    inValid8 = 1'b0;
    lat = 0;
    while (!outValid8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic doOp16(input logic [15:0] a, input logic [15:0] b, input logic m, output int lat);
    a16 = a; b16 = b; mode16 = m; inValid16 = 1'b1;
    @(posedge clk); #1;
    inValid16 = 1'b0;
    lat = 0;
    while (!outValid16 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release8();
    outReady8 = 1'b1;
    @(posedge clk); #1;
    outReady8 = 1'b0;
  endtask

  task automatic release16();
    outReady16 = 1'b1;
    @(posedge clk); #1;
    outReady16 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inValid8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    inValid8 = 1'b0;
    checks++;
    if ({inReady8, outValid8, s8, cout8, ovf8, zero8} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
      errors++;
      $display("[TB] FAIL reset8: rdy=%b vld=%b S=%h C=%b V=%b Z=%b, expected rdy=1 vld=0 S=00 C=0 V=0 Z=0",
               inReady8, outValid8, s8, cout8, ovf8, zero8);
    end
    checks++;
    if ({inReady16, outValid16, s16, cout16, ovf16, zero16} !== {1'b1, 1'b0, 16'h0000, 3'b000}) begin
      errors++;
      $display("[TB] FAIL reset16: rdy=%b vld=%b S=%h C=%b V=%b Z=%b, expected rdy=1 vld=0 S=0000 flags=0",
               inReady16, outValid16, s16, cout16, ovf16, zero16);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (inReady8 !== 1'b1 || outValid8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ignored_valid: rdy=%b vld=%b, expected rdy=1 vld=0", inReady8, outValid8);
    end
  endtask

  task automatic test_sub();
    logic [7:0] vecA [3];
    logic [7:0] vecB [3];
    logic [10:0] expect_ [3];
    int lat;
    vecA = '{8'h05, 8'h03, 8'h80};
    vecB = '{8'h03, 8'h05, 8'h01};
    // {S, Cout, ovf, zero}
    expect_ = '{{8'h02, 3'b000}, {8'hFE, 3'b100}, {8'h7F, 3'b010}};
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (inReady8 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL sub_ready[%0d]: in_ready=%b, expected 1", i, inReady8);
      end
      doOp8(vecA[i], vecB[i], 1'b0, lat);
      checks++;
      if (lat !== 8) begin
        errors++;
        $display("[TB] FAIL sub_latency[%0d]: got %0d cycles, expected 8", i, lat);
      end
      checks++;
      if ({s8, cout8, ovf8, zero8} !== expect_[i]) begin
        errors++;
        $display("[TB] FAIL sub[%0d] %h-%h: S=%h C=%b V=%b Z=%b, expected S=%h C=%b V=%b Z=%b",
                 i, vecA[i], vecB[i], s8, cout8, ovf8, zero8,
                 expect_[i][10:3], expect_[i][2], expect_[i][1], expect_[i][0]);
      end
      release8();
    end
  endtask

  task automatic test_add();
    logic [7:0] vecA [2];
    logic [7:0] vecB [2];
    logic [10:0] expect_ [2];
    int lat;
    vecA = '{8'h7F, 8'hFF};
    vecB = '{8'h01, 8'h01};
    expect_ = '{{8'h80, 3'b010}, {8'h00, 3'b101}};
    for (int i = 0; i < 2; i++) begin
      doOp8(vecA[i], vecB[i], 1'b1, lat);
      checks++;
      if (lat !== 8 || {s8, cout8, ovf8, zero8} !== expect_[i]) begin
        errors++;
        $display("[TB] FAIL add[%0d] %h+%h: lat=%0d S=%h C=%b V=%b Z=%b, expected lat=8 S=%h C=%b V=%b Z=%b",
                 i, vecA[i], vecB[i], lat, s8, cout8, ovf8, zero8,
                 expect_[i][10:3], expect_[i][2], expect_[i][1], expect_[i][0]);
      end
      release8();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    doOp8(8'h12, 8'h34, 1'b1, lat);
    for (int i = 0; i < 5; i++) begin
      inValid8 = 1'b1;
      a8 = 8'hA0 + 8'(i);
      b8 = 8'h0F - 8'(i);
      @(posedge clk); #1;
      checks++;
      if ({outValid8, inReady8, s8, cout8, ovf8, zero8} !== {1'b1, 1'b0, 8'h46, 3'b000}) begin
        errors++;
        $display("[TB] FAIL hold[%0d]: vld=%b rdy=%b S=%h C=%b V=%b Z=%b, expected vld=1 rdy=0 S=46 C=0 V=0 Z=0",
                 i, outValid8, inReady8, s8, cout8, ovf8, zero8);
      end
    end
    inValid8 = 1'b0;
    release8();
    checks++;
    if (inReady8 !== 1'b1 || outValid8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release: rdy=%b vld=%b, expected rdy=1 vld=0", inReady8, outValid8);
    end
    @(posedge clk); #1;
    checks++;
    if (inReady8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_stays: rdy=%b, expected 1", inReady8);
    end
  endtask

  task automatic test_reset_midop();
    int lat;
    a8 = 8'h05; b8 = 8'h03; mode8 = 1'b0; inValid8 = 1'b1;
    @(posedge clk); #1;
    inValid8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({outValid8, inReady8, s8, cout8} !== {1'b0, 1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL midop_reset: vld=%b rdy=%b S=%h C=%b, expected vld=0 rdy=1 S=00 C=0",
               outValid8, inReady8, s8, cout8);
    end
    doOp8(8'h5A, 8'h5A, 1'b0, lat);
    checks++;
    if (lat !== 8 || {s8, cout8, ovf8, zero8} !== {8'h00, 3'b001}) begin
      errors++;
      $display("[TB] FAIL after_reset_sub: lat=%0d S=%h C=%b V=%b Z=%b, expected lat=8 S=00 C=0 V=0 Z=1",
               lat, s8, cout8, ovf8, zero8);
    end
    release8();
  endtask

  task automatic test_wide();
    int lat;
    logic [15:0] ra, rb, expS;
    logic [16:0] full;
    logic expC, expV, m;
    int sa, sb, res;
    doOp16(16'h1234, 16'h1235, 1'b0, lat);
    checks++;
    if (lat !== 4 || {s16, cout16, ovf16, zero16} !== {16'hFFFF, 3'b100}) begin
      errors++;
      $display("[TB] FAIL wide_sub: lat=%0d S=%h C=%b V=%b Z=%b, expected lat=4 S=FFFF C=1 V=0 Z=0",
               lat, s16, cout16, ovf16, zero16);
    end
    release16();
    doOp16(16'h7FFF, 16'h0001, 1'b1, lat);
    checks++;
    if ({s16, cout16, ovf16, zero16} !== {16'h8000, 3'b010}) begin
      errors++;
      $display("[TB] FAIL wide_add_ovf: S=%h C=%b V=%b Z=%b, expected S=8000 C=0 V=1 Z=0",
               s16, cout16, ovf16, zero16);
    end
    release16();
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      m  = i[0];
      sa = int'($signed(ra));
      sb = int'($signed(rb));
      if (m) begin
        full = {1'b0, ra} + {1'b0, rb};
        expS = full[15:0];
        expC = full[16];
        res  = sa + sb;
      end else begin
        expS = ra - rb;
        expC = (ra < rb);
        res  = sa - sb;
      end
      expV = (res > 32767) || (res < -32768);
      doOp16(ra, rb, m, lat);
      checks++;
      if (lat !== 4 || {s16, cout16, ovf16, zero16} !== {expS, expC, expV, (expS == 16'h0)}) begin
        errors++;
        $display("[TB] FAIL wide_rand[%0d] mode=%b %h,%h: lat=%0d S=%h C=%b V=%b Z=%b, expected lat=4 S=%h C=%b V=%b Z=%b",
                 i, m, ra, rb, lat, s16, cout16, ovf16, zero16, expS, expC, expV, (expS == 16'h0));
      end
      release16();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    inValid8 = 1'b0; outReady8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
    inValid16 = 1'b0; outReady16 = 1'b0; mode16 = 1'b0; a16 = '0; b16 = '0;
    test_reset();
    test_sub();
    test_add();
    test_backpressure();
    test_reset_midop();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
